// File: rtl/aes_pkg.sv
// Shared definitions for the AES request scheduler: block width and FSM encoding.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset down so the nearest candidate to rr_ptr wins.
    always_comb begin
        grant   = '0;
        any_req = |req;
        sum     = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/aes_req_scheduler.sv
// Shares a single aes_core among NUM_REQ requesters with round-robin arbitration,
// one job in flight, and a watchdog that turns a hung core into an error response.
module aes_req_scheduler
    import aes_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   req_key_in,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   req_text_in,
    input  logic [NUM_REQ-1:0]             req_en_or_de_in,
    output logic [NUM_REQ-1:0]             resp_valid_out,
    output logic [AES_BLK_W-1:0]           resp_text_out,
    output logic                           resp_error_out,
    output logic                           busy_out,
    output logic                           core_start_out,
    output logic [AES_BLK_W-1:0]           core_key_out,
    output logic [AES_BLK_W-1:0]           core_text_out,
    output logic                           core_en_or_de_out,
    input  logic [AES_BLK_W-1:0]           core_text_in,
    input  logic                           core_ready_in,
    output logic [1:0]                     dbg_state
);

    // Handshake: a request transfers when req_valid_in[r] and req_ready_out[r] are both
    // high in one cycle; the requester holds valid and data stable until then.
    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_t         state, state_nxt;
    logic [IDX_W-1:0]     rr_ptr, grant, grant_idx;
    logic                 any_req;
    logic [AES_BLK_W-1:0] key_q, text_q;
    logic                 en_q;
    logic                 armed;
    logic [CNT_W-1:0]     cnt;
    logic                 ready_hit, timeout_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req_valid_in),
        .rr_ptr  (rr_ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    // armed filters out a ready level left over from the previous job.
    assign ready_hit   = armed & core_ready_in;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (ready_hit || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_out  = '0;
        resp_valid_out = '0;
        core_start_out = 1'b0;
        case (state)
            IDLE:    if (any_req) req_ready_out[grant] = 1'b1;
            START:   core_start_out = 1'b1;
            RESP:    resp_valid_out[grant_idx] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr         <= '0;
            grant_idx      <= '0;
            key_q          <= '0;
            text_q         <= '0;
            en_q           <= 1'b0;
            armed          <= 1'b0;
            cnt            <= '0;
            resp_text_out  <= '0;
            resp_error_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        key_q     <= req_key_in[AES_BLK_W*int'(grant) +: AES_BLK_W];
                        text_q    <= req_text_in[AES_BLK_W*int'(grant) +: AES_BLK_W];
                        en_q      <= req_en_or_de_in[grant];
                        grant_idx <= grant;
                        rr_ptr    <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    end
                end
                START: begin
                    cnt   <= '0;
                    armed <= 1'b0;
                end
                WAIT: begin
                    if (!core_ready_in) armed <= 1'b1;
                    // A qualifying ready beats a simultaneous timeout.
                    if (ready_hit) begin
                        resp_text_out  <= core_text_in;
                        resp_error_out <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_text_out  <= '0;
                        resp_error_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_out          = (state != IDLE);
    assign core_key_out      = key_q;
    assign core_text_out     = text_q;
    assign core_en_or_de_out = en_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Bench for aes_req_scheduler with a behavioural aes_core stand-in and a response scoreboard.
module tb_aes_req_scheduler;

    localparam int NR = 4;
    localparam int TO = 16;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*128-1:0] req_key, req_text;
    logic [NR-1:0]     req_en;
    logic [NR-1:0]     resp_valid;
    logic [127:0]      resp_text;
    logic              resp_error, busy, core_start, core_en;
    logic [127:0]      core_key, core_text_o;
    logic [127:0]      core_text = '0;
    logic              core_ready = 1'b0;
    logic [1:0]        dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [130:0] exp_q[$];   // {requester[1:0], text[127:0], error}

    bit hang = 0;
    bit stale_mode = 0;
    int core_lat = 4;

    logic [NR-1:0] o_acc, o_rdy, o_rv;
    logic [127:0]  o_rt, o_ck, o_ct;
    logic [1:0]    o_st;
    logic          o_re, o_bz, o_cs, o_ce, o_cr;

    always #5 clk = ~clk;

    aes_req_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid_in      (req_valid),
        .req_ready_out     (req_ready),
        .req_key_in        (req_key),
        .req_text_in       (req_text),
        .req_en_or_de_in   (req_en),
        .resp_valid_out    (resp_valid),
        .resp_text_out     (resp_text),
        .resp_error_out    (resp_error),
        .busy_out          (busy),
        .core_start_out    (core_start),
        .core_key_out      (core_key),
        .core_text_out     (core_text_o),
        .core_en_or_de_out (core_en),
        .core_text_in      (core_text),
        .core_ready_in     (core_ready),
        .dbg_state         (dbg_state)
    );

    // Stand-in for aes_core: the FIPS-197 vector in both directions, a keyed permutation otherwise.
    function automatic logic [127:0] core_fn(logic [127:0] k, logic [127:0] t, logic en);
        if (en && k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        if (!en && k == FIPS_KEY && t == FIPS_CT) return FIPS_PT;
        return {t[63:0], t[127:64]} ^ k ^ {128{en}};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic         m_busy = 1'b0;
    int           m_lat = 0;
    int           m_drop = 0;
    logic [127:0] m_job = '0;

    // Ready is a level held until the next start; stale_mode keeps it high a few cycles past start.
    always @(posedge clk) begin
        if (reset) begin
            core_ready <= 1'b0;
            m_busy     <= 1'b0;
            m_drop     <= 0;
        end else if (core_start) begin
            m_busy <= !hang;
            m_lat  <= core_lat;
            m_job  <= core_fn(core_key, core_text_o, core_en);
            if (stale_mode) m_drop <= 3;
            else            core_ready <= 1'b0;
        end else if (m_drop != 0) begin
            m_drop <= m_drop - 1;
            if (m_drop == 1) core_ready <= 1'b0;
        end else if (m_busy) begin
            if (m_lat == 0) begin
                core_ready <= 1'b1;
                core_text  <= m_job;
                m_busy     <= 1'b0;
            end else begin
                m_lat <= m_lat - 1;
            end
        end
    end

    // One cycle: observe outputs at negedge, log accepted requests, then drop their valid.
    task automatic step();
        @(negedge clk);
        cyc++;
        o_rdy = req_ready;
        o_acc = req_valid & req_ready;
        o_rv  = resp_valid;
        o_rt  = resp_text;
        o_re  = resp_error;
        o_bz  = busy;
        o_st  = dbg_state;
        o_cs  = core_start;
        o_ck  = core_key;
        o_ct  = core_text_o;
        o_ce  = core_en;
        o_cr  = core_ready;
        for (int r = 0; r < NR; r++) begin
            if (o_acc[r]) begin
                exp_q.push_back(hang ? {2'(r), 128'b0, 1'b1}
                                     : {2'(r), core_fn(req_key[r*128 +: 128], req_text[r*128 +: 128], req_en[r]), 1'b0});
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~o_acc;
    endtask

    task automatic set_req(int r, logic [127:0] k, logic [127:0] t, logic en);
        req_key[r*128 +: 128]  = k;
        req_text[r*128 +: 128] = t;
        req_en[r]              = en;
        req_valid[r]           = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if ({o_bz, o_st, o_cs, o_rv, o_rdy} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy=%b state=%0d start=%b resp_valid=%b ready=%b, want all 0", o_bz, o_st, o_cs, o_rv, o_rdy);
        end
        vectors++;
        if ({o_rt, o_re} !== '0) begin
            miscompares++;
            $display("FAIL reset_resp: text=%h err=%b, want 0", o_rt, o_re);
        end
        vectors++;
        if ({o_ck, o_ct, o_ce} !== '0) begin
            miscompares++;
            $display("FAIL reset_core: key=%h text=%h en=%b, want 0", o_ck, o_ct, o_ce);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (o_bz !== 1'b0 || o_rdy !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b ready=%b, want 0/0000", o_bz, o_rdy);
        end
    endtask

    task automatic test_single(int r, logic [127:0] k, logic [127:0] t, logic en, logic [127:0] want);
        logic [130:0] e;
        int t_acc = -100;
        int nresp = 0;
        core_lat = 4;
        set_req(r, k, t, en);
        for (int c = 0; c < 40; c++) begin
            step();
            if (o_acc != '0) begin
                t_acc = cyc;
                vectors++;
                if (o_acc !== (4'b0001 << r)) begin
                    miscompares++;
                    $display("FAIL single_grant: accept=%b, want %b", o_acc, 4'b0001 << r);
                end
            end
            if (o_cs) begin
                vectors++;
                if (cyc != t_acc + 1 || o_ck !== k || o_ct !== t || o_ce !== en) begin
                    miscompares++;
                    $display("FAIL single_start: start at +%0d key=%h text=%h en=%b, want +1 key=%h text=%h en=%b", cyc - t_acc, o_ck, o_ct, o_ce, k, t, en);
                end
            end
            if (o_rv != '0) begin
                nresp++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL single_resp: resp_valid=%b with nothing outstanding", o_rv);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_rv, o_rt, o_re} !== {4'b0001 << e[130:129], e[128:1], e[0]}) begin
                        miscompares++;
                        $display("FAIL single_resp: got %b/%h/%b, want %b/%h/%b", o_rv, o_rt, o_re, 4'b0001 << e[130:129], e[128:1], e[0]);
                    end
                end
                vectors++;
                if (o_rt !== want) begin
                    miscompares++;
                    $display("FAIL single_vector: text=%h, want %h", o_rt, want);
                end
            end
        end
        vectors++;
        if (nresp != 1) begin
            miscompares++;
            $display("FAIL single_count: %0d responses, want 1", nresp);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]   masks [5] = '{4'b1111, 4'b0010, 4'b1001, 4'b1001, 4'b0110};
        int           exp_grant [11] = '{0, 1, 2, 3, 1, 3, 0, 3, 0, 1, 2};
        logic [130:0] e;
        int gi = 0;
        int nresp = 0;
        int want = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int s = 0; s < 5; s++) begin
            for (int r = 0; r < NR; r++) begin
                if (masks[s][r]) set_req(r, rand128(), rand128(), 1'($urandom_range(0, 1)));
            end
            want += $countones(masks[s]);
            for (int c = 0; c < 150 && nresp < want; c++) begin
                core_lat = $urandom_range(1, 8);
                step();
                if (o_acc != '0) begin
                    vectors++;
                    if (gi >= 11 || o_acc !== (4'b0001 << exp_grant[gi])) begin
                        miscompares++;
                        $display("FAIL rr_grant: accept #%0d=%b, want %b", gi, o_acc, 4'b0001 << exp_grant[gi % 11]);
                    end
                    gi++;
                end
                if (o_st != 2'd0) begin
                    vectors++;
                    if (o_rdy !== '0) begin
                        miscompares++;
                        $display("FAIL rr_ready_busy: ready=%b in state %0d, want 0000", o_rdy, o_st);
                    end
                end
                if (o_rv != '0) begin
                    nresp++;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL rr_resp: resp_valid=%b with nothing outstanding", o_rv);
                    end else begin
                        e = exp_q.pop_front();
                        if ({o_rv, o_rt, o_re} !== {4'b0001 << e[130:129], e[128:1], e[0]}) begin
                            miscompares++;
                            $display("FAIL rr_resp: got %b/%h/%b, want %b/%h/%b", o_rv, o_rt, o_re, 4'b0001 << e[130:129], e[128:1], e[0]);
                        end
                    end
                end
            end
            vectors++;
            if (nresp != want) begin
                miscompares++;
                $display("FAIL rr_drain: stage %0d has %0d responses, want %0d", s, nresp, want);
            end
        end
    endtask

    task automatic test_timeout();
        logic [130:0] e;
        int t_acc = -100;
        int nresp = 0;
        hang = 1;
        set_req(2, rand128(), rand128(), 1'b1);
        for (int c = 0; c < 40; c++) begin
            step();
            if (o_acc != '0) t_acc = cyc;
            if (o_rv != '0) begin
                nresp++;
                vectors++;
                if (cyc - t_acc != 18) begin
                    miscompares++;
                    $display("FAIL timeout_latency: response %0d cycles after accept, want 18", cyc - t_acc);
                end
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL timeout_resp: resp_valid=%b with nothing outstanding", o_rv);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_rv, o_rt, o_re} !== {4'b0001 << e[130:129], e[128:1], e[0]}) begin
                        miscompares++;
                        $display("FAIL timeout_resp: got %b/%h/%b, want %b/%h/%b", o_rv, o_rt, o_re, 4'b0001 << e[130:129], e[128:1], e[0]);
                    end
                end
            end
        end
        vectors++;
        if (nresp != 1) begin
            miscompares++;
            $display("FAIL timeout_count: %0d responses, want 1", nresp);
        end
        hang = 0;
    endtask

    task automatic test_stale_ready();
        logic [130:0] e;
        int nresp = 0;
        bit started = 0;
        bit saw_low = 0;
        core_lat = 3;
        set_req(0, rand128(), rand128(), 1'b1);
        for (int c = 0; c < 80 && nresp < 2; c++) begin
            if (nresp == 1 && !stale_mode) begin
                stale_mode = 1;
                core_lat   = 4;
                set_req(1, rand128(), rand128(), 1'b0);
            end
            step();
            if (stale_mode && o_acc != '0) started = 1;
            if (started && !o_cr) saw_low = 1;
            if (o_rv != '0) begin
                nresp++;
                if (stale_mode) begin
                    vectors++;
                    if (!saw_low) begin
                        miscompares++;
                        $display("FAIL stale_early: response %b before core ready went low", o_rv);
                    end
                end
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stale_resp: resp_valid=%b with nothing outstanding", o_rv);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_rv, o_rt, o_re} !== {4'b0001 << e[130:129], e[128:1], e[0]}) begin
                        miscompares++;
                        $display("FAIL stale_resp: got %b/%h/%b, want %b/%h/%b", o_rv, o_rt, o_re, 4'b0001 << e[130:129], e[128:1], e[0]);
                    end
                end
            end
        end
        vectors++;
        if (nresp != 2) begin
            miscompares++;
            $display("FAIL stale_count: %0d responses, want 2", nresp);
        end
        stale_mode = 0;
    endtask

    task automatic test_reset_mid_wait();
        logic [130:0] e;
        int nresp = 0;
        int first = -1;
        bit spurious = 0;
        hang = 1;
        set_req(1, rand128(), rand128(), 1'b1);
        for (int c = 0; c < 10 && req_valid[1]; c++) step();
        for (int c = 0; c < 5; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        hang = 0;
        exp_q.delete();
        step();
        vectors++;
        if (o_bz !== 1'b0 || o_st !== 2'd0) begin
            miscompares++;
            $display("FAIL midreset_busy: busy=%b state=%0d after reset, want 0/0", o_bz, o_st);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            if (o_rv != '0) spurious = 1;
        end
        vectors++;
        if (spurious) begin
            miscompares++;
            $display("FAIL midreset_drop: response issued for the dropped job, want none");
        end
        set_req(0, rand128(), rand128(), 1'b1);
        set_req(2, rand128(), rand128(), 1'b0);
        for (int c = 0; c < 60 && nresp < 2; c++) begin
            core_lat = $urandom_range(1, 6);
            step();
            if (o_acc != '0 && first < 0) begin
                first = 1;
                vectors++;
                if (o_acc !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL midreset_grant: first accept=%b, want 0001", o_acc);
                end
            end
            if (o_rv != '0) begin
                nresp++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL midreset_resp: resp_valid=%b with nothing outstanding", o_rv);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_rv, o_rt, o_re} !== {4'b0001 << e[130:129], e[128:1], e[0]}) begin
                        miscompares++;
                        $display("FAIL midreset_resp: got %b/%h/%b, want %b/%h/%b", o_rv, o_rt, o_re, 4'b0001 << e[130:129], e[128:1], e[0]);
                    end
                end
            end
        end
        vectors++;
        if (nresp != 2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL midreset_count: %0d responses, %0d outstanding, want 2/0", nresp, exp_q.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_key   = '0;
        req_text  = '0;
        req_en    = '0;
        test_reset();
        test_single(0, FIPS_KEY, FIPS_PT, 1'b1, FIPS_CT);
        test_single(2, FIPS_KEY, FIPS_CT, 1'b0, FIPS_PT);
        test_round_robin();
        test_timeout();
        test_stale_ready();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
